// File: rtl/cdb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin onto a registered
// common data bus, one broadcast per cycle unless cdb_hold is asserted.
module cdb_arbiter #(
  parameter int FU_COUNT  = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [FU_COUNT-1:0]                        fu_result_valid,
  input  logic [FU_COUNT*8-1:0]                      fu_result_val,
  input  logic [FU_COUNT*4-1:0]                      fu_result_tag,
  input  logic [FU_COUNT*8-1:0]                      fu_result_flags,
  output logic [FU_COUNT-1:0]                        fu_result_ready,
  input  logic                                       cdb_hold,
  output logic [7:0]                                 cdbval,
  output logic [3:0]                                 cdbid,
  output logic [7:0]                                 cdbflags,
  output logic                                       cdbtransmit,
  output logic [$clog2(FU_COUNT*BUF_DEPTH+1)-1:0]    pending
);

  localparam int IW  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int IW1 = IW + 1;
  localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int NW  = $clog2(FU_COUNT * BUF_DEPTH + 1);
  localparam int EW  = 20;

  localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(BUF_DEPTH - 1);
  localparam logic [IW:0]   FU_COUNT_C = IW1'(FU_COUNT);
  localparam logic [IW-1:0] RR_LAST    = IW'(FU_COUNT - 1);

  logic [EW-1:0]   mem_r      [FU_COUNT][BUF_DEPTH];
  logic [CW-1:0]   cnt_r      [FU_COUNT];
  logic [CW-1:0]   cnt_nxt_s  [FU_COUNT];
  logic [PW-1:0]   rptr_r     [FU_COUNT];
  logic [PW-1:0]   wptr_r     [FU_COUNT];
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   winner_s;
  logic [IW:0]     idx_s;
  logic            found_s;
  logic            grant_s;
  logic [FU_COUNT-1:0] push_s;
  logic [FU_COUNT-1:0] pop_s;
  logic [NW-1:0]   pending_nxt_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Readiness comes only from registered counts, so a full FIFO refuses even while popped.
  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_result_ready[i] = (cnt_r[i] != DEPTH_C);
    end
  end

  // Round-robin search starting at rr_ptr for the first non-empty FIFO.
  always_comb begin
    found_s  = 1'b0;
    winner_s = rr_ptr_r;
    idx_s    = {IW1{1'b0}};
    for (int k = 0; k < FU_COUNT; k++) begin
      idx_s = {1'b0, rr_ptr_r} + IW1'(k);
      if (idx_s >= FU_COUNT_C) begin
        idx_s = idx_s - FU_COUNT_C;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && (cnt_r[idx_s[IW-1:0]] != {CW{1'b0}})) begin
        found_s  = 1'b1;
        winner_s = idx_s[IW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
    grant_s = found_s & ~cdb_hold;
  end

  // Per-FIFO push/pop decisions, next counts and the next pending total.
  always_comb begin
    pending_nxt_s = {NW{1'b0}};
    for (int i = 0; i < FU_COUNT; i++) begin
      push_s[i] = fu_result_valid[i] & fu_result_ready[i];
      pop_s[i]  = grant_s & (winner_s == IW'(i));
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_nxt_s[i] = cnt_r[i] + CW'(1);
        2'b01:   cnt_nxt_s[i] = cnt_r[i] - CW'(1);
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
      pending_nxt_s = pending_nxt_s + NW'(cnt_nxt_s[i]);
    end
  end

  // Result storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_COUNT; i++) begin
      if (push_s[i]) begin
        mem_r[i][wptr_r[i]] <= {fu_result_val[i*8 +: 8], fu_result_tag[i*4 +: 4],
                                fu_result_flags[i*8 +: 8]};
      end
    end
  end

  // FIFO control state, round-robin pointer and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FU_COUNT; i++) begin
        cnt_r[i]  <= {CW{1'b0}};
        rptr_r[i] <= {PW{1'b0}};
        wptr_r[i] <= {PW{1'b0}};
      end
      rr_ptr_r    <= {IW{1'b0}};
      cdbval      <= 8'h00;
      cdbid       <= 4'h0;
      cdbflags    <= 8'h00;
      cdbtransmit <= 1'b0;
      pending     <= {NW{1'b0}};
    end else begin
      for (int i = 0; i < FU_COUNT; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
        if (push_s[i]) begin
          wptr_r[i] <= ptr_inc(wptr_r[i]);
        end
        if (pop_s[i]) begin
          rptr_r[i] <= ptr_inc(rptr_r[i]);
        end
      end
      cdbtransmit <= grant_s;
      pending     <= pending_nxt_s;
      if (grant_s) begin
        rr_ptr_r <= (winner_s == RR_LAST) ? {IW{1'b0}} : winner_s + IW'(1);
        {cdbval, cdbid, cdbflags} <= mem_r[winner_s][rptr_r[winner_s]];
      end
    end
  end

endmodule
